// File: rtl/dii_package.sv
// Debug interconnect flit type shared by all DII endpoints.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/opensocdebug.sv
// Shared Open SoC Debug constants and event record.
package opensocdebug;

  // Packet type field (flags[15:14]) and STM sub-type (flags[13:10])
  localparam logic [1:0] TYPE_EVENT   = 2'b10;
  localparam logic [3:0] TYPE_SUB_STM = 4'h0;

  // Widest trace value the event record can carry
  localparam int unsigned EV_MAX_XLEN = 64;

  typedef struct packed {
    logic [15:0]            src;
    logic [31:0]            timestamp;
    logic [15:0]            id;
    logic [EV_MAX_XLEN-1:0] value;
  } stm_event_t;

endpackage

// File: rtl/osd_stm_event_rx.sv
// STM event packet receiver: parses DII event packets addressed to this
// endpoint into a single held event record, counts malformed packets.
module osd_stm_event_rx
  import dii_package::*;
  import opensocdebug::*;
#(
  parameter int unsigned XLEN = 32  // must be a multiple of 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      id,
  input  dii_flit         debug_in,
  output logic            debug_in_ready,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [15:0]     ev_src,
  output logic [31:0]     ev_timestamp,
  output logic [15:0]     ev_id,
  output logic [XLEN-1:0] ev_value,
  output logic [15:0]     err_count
);

  localparam int unsigned NumWords = XLEN / 16;
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

  localparam logic [3:0] StDest  = 4'd0;
  localparam logic [3:0] StSrc   = 4'd1;
  localparam logic [3:0] StFlags = 4'd2;
  localparam logic [3:0] StTs0   = 4'd3;
  localparam logic [3:0] StTs1   = 4'd4;
  localparam logic [3:0] StId    = 4'd5;
  localparam logic [3:0] StVal   = 4'd6;
  localparam logic [3:0] StDrop  = 4'd7;
  localparam logic [3:0] StHold  = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [IdxW-1:0] word_idx_q;
  logic            err_inc;
  logic            xfer;
  logic            flit_last;
  logic            dest_match;
  logic            flags_ok;
  logic            idx_last;

  assign debug_in_ready = (state_q != StHold);
  assign ev_valid       = (state_q == StHold);
  assign xfer           = debug_in.valid && debug_in_ready;
  assign flit_last      = debug_in.last;
  assign dest_match     = (debug_in.data[9:0] == id) && (debug_in.data[15:10] == 6'd0);
  assign flags_ok       = (debug_in.data[15:14] == TYPE_EVENT) &&
                          (debug_in.data[13:10] == TYPE_SUB_STM);
  assign idx_last       = (word_idx_q == LastIdx);

  // Next state and error strobe; at most one error per accepted flit.
  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    if (state_q == StHold) begin
      if (ev_ready) state_d = StDest;
    end else if (xfer) begin
      case (state_q)
        StDest: begin
          if (dest_match) begin
            // a matching single-flit packet is malformed
            state_d = flit_last ? StDest : StSrc;
            err_inc = flit_last;
          end else begin
            state_d = flit_last ? StDest : StDrop;
          end
        end
        StSrc: begin
          state_d = flit_last ? StDest : StFlags;
          err_inc = flit_last;
        end
        StFlags: begin
          if (flit_last) begin
            state_d = StDest;
            err_inc = 1'b1;
          end else if (flags_ok) begin
            state_d = StTs0;
          end else begin
            state_d = StDrop;
            err_inc = 1'b1;
          end
        end
        StTs0: begin
          state_d = flit_last ? StDest : StTs1;
          err_inc = flit_last;
        end
        StTs1: begin
          state_d = flit_last ? StDest : StId;
          err_inc = flit_last;
        end
        StId: begin
          state_d = flit_last ? StDest : StVal;
          err_inc = flit_last;
        end
        StVal: begin
          if (idx_last) begin
            state_d = flit_last ? StHold : StDrop;
            err_inc = !flit_last;
          end else if (flit_last) begin
            state_d = StDest;
            err_inc = 1'b1;
          end
        end
        StDrop: begin
          if (flit_last) state_d = StDest;
        end
        default: state_d = StDest;
      endcase
    end
  end

  // State, field capture and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StDest;
      word_idx_q   <= '0;
      err_count    <= 16'd0;
      ev_src       <= 16'd0;
      ev_timestamp <= 32'd0;
      ev_id        <= 16'd0;
      ev_value     <= '0;
    end else begin
      state_q <= state_d;
      if (err_inc && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      // Fields only move on accepted flits, so they are frozen throughout HOLD
      if (xfer) begin
        case (state_q)
          StSrc:   ev_src             <= debug_in.data;
          StTs0:   ev_timestamp[15:0]  <= debug_in.data;
          StTs1:   ev_timestamp[31:16] <= debug_in.data;
          StId: begin
            ev_id      <= debug_in.data;
            word_idx_q <= '0;
          end
          StVal: begin
            for (int w = 0; w < NumWords; w++) begin
              if (word_idx_q == IdxW'(w)) ev_value[w*16 +: 16] <= debug_in.data;
            end
            word_idx_q <= (idx_last || flit_last) ? '0 : word_idx_q + IdxW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osd_stm_event_rx.sv
// Randomized self-checking bench for osd_stm_event_rx with a packet-level model.
module tb_osd_stm_event_rx;
  import dii_package::*;
  import opensocdebug::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NW     = XLEN / 16;
  localparam int unsigned PktLen = 6 + NW;
  localparam logic [9:0]  DutId  = 10'd5;

  logic            clk;
  logic            rst;
  dii_flit         debug_in;
  logic            debug_in_ready;
  logic            ev_valid;
  logic            ev_ready = 1'b0;
  logic [15:0]     ev_src;
  logic [31:0]     ev_timestamp;
  logic [15:0]     ev_id;
  logic [XLEN-1:0] ev_value;
  logic [15:0]     err_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        ev_block = 1'b1;
  stm_event_t  exp_q[$];
  logic [15:0] err_model = 16'd0;
  logic [15:0] pkt[$];

  osd_stm_event_rx #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .id             (DutId),
    .debug_in       (debug_in),
    .debug_in_ready (debug_in_ready),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_src         (ev_src),
    .ev_timestamp   (ev_timestamp),
    .ev_id          (ev_id),
    .ev_value       (ev_value),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Consumer: random ready unless blocked
  always @(posedge clk) begin
    #1;
    ev_ready = !ev_block && ($urandom_range(0, 3) != 0);
  end

  // Event monitor: every held cycle must show the expected record
  always @(negedge clk) begin
    if (!rst && ev_valid) begin
      check_eq("ready_in_hold", debug_in_ready, 1'b0);
      if (exp_q.size() == 0) begin
        check_eq("ev_unexpected", ev_valid, 1'b0);
      end else begin
        check_eq("ev_src", ev_src, exp_q[0].src);
        check_eq("ev_timestamp", ev_timestamp, exp_q[0].timestamp);
        check_eq("ev_id", ev_id, exp_q[0].id);
        check_eq("ev_value", ev_value, exp_q[0].value[XLEN-1:0]);
        if (ev_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Packet-level reference: a packet is everything up to and including a last flit
  function automatic bit model_packet(input logic [15:0] w[$]);
    stm_event_t ev;
    int n = w.size();
    if (w[0][9:0] == DutId && w[0][15:10] == 6'd0) begin
      if (n == PktLen && w[2][15:14] == 2'b10 && w[2][13:10] == 4'd0) begin
        ev.src       = w[1];
        ev.timestamp = {w[4], w[3]};
        ev.id        = w[5];
        ev.value     = '0;
        for (int k = 0; k < NW; k++) ev.value[16*k +: 16] = w[6+k];
        exp_q.push_back(ev);
        return 1'b1;
      end
      if (err_model != 16'hFFFF) err_model = err_model + 16'd1;
    end
    return 1'b0;
  endfunction

  task automatic send_flit(input logic [15:0] data, input logic last);
    int   waited = 0;
    logic acc    = 1'b0;
    debug_in.valid = 1'b1;
    debug_in.last  = last;
    debug_in.data  = data;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = debug_in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
    debug_in.valid = 1'b0;
    debug_in.last  = 1'b0;
    debug_in.data  = 16'($urandom);
  endtask

  task automatic send_packet(input bit gaps);
    bit exp_ev;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_flit(pkt[i], i == pkt.size() - 1);
    end
    exp_ev = model_packet(pkt);
    @(negedge clk);
    check_eq("ev_valid_after_last", ev_valid, exp_ev);
    check_eq("err_count", err_count, err_model);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    debug_in.valid = 1'b0;
    exp_q.delete();
    err_model = 16'd0;
    @(negedge clk);
    check_eq("rst_ev_valid", ev_valid, 1'b0);
    check_eq("rst_err_count", err_count, 16'd0);
    check_eq("rst_ready", debug_in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic void build_good();
    pkt = {};
    pkt.push_back({6'd0, DutId});
    pkt.push_back(16'($urandom));
    pkt.push_back({6'b100000, 10'($urandom)});
    for (int i = 0; i < 3 + NW; i++) pkt.push_back(16'($urandom));
  endfunction

  initial begin
    logic [15:0] w0;
    int          kind;
    debug_in = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ev_valid", ev_valid, 1'b0);
    check_eq("rst_err_count", err_count, 16'd0);
    check_eq("rst_ready", debug_in_ready, 1'b1);
    check_eq("rst_ev_data", {ev_src, ev_id, ev_timestamp}, 64'd0);
    check_eq("rst_ev_value", ev_value, 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ev_block = 1'b0;

    // Reference packet
    pkt = {16'h0005, 16'h0003, 16'h8000, 16'h1234, 16'h0001, 16'h00AB, 16'hBEEF, 16'hDEAD};
    send_packet(1'b0);

    // Held event: consumer stalls for 10 cycles, next packet waits behind it
    ev_block = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_packet(1'b0);
    repeat (10) begin
      @(negedge clk);
      check_eq("hold_valid", ev_valid, 1'b1);
      check_eq("hold_ready", debug_in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    ev_block = 1'b0;
    build_good();
    send_packet(1'b0);

    // Foreign destination
    pkt = {16'h0007, 16'h0003, 16'h8000, 16'h1234, 16'h0001, 16'h00AB, 16'hBEEF, 16'hDEAD};
    send_packet(1'b0);

    // Early last on the ID flit, then a good packet
    pkt = {16'h0005, 16'h0003, 16'h8000, 16'h1234, 16'h0001, 16'h00AB};
    send_packet(1'b0);
    build_good();
    send_packet(1'b1);

    // Wrong type, then missing last on the final value word
    pkt = {16'h0005, 16'h0003, 16'h4000, 16'h1234, 16'h0001, 16'h00AB, 16'hBEEF, 16'hDEAD};
    send_packet(1'b0);
    pkt = {16'h0005, 16'h0003, 16'h8000, 16'h1234, 16'h0001, 16'h00AB, 16'hBEEF, 16'hDEAD,
           16'h0000};
    send_packet(1'b0);

    // Reset after TS1; tail re-parsed as a packet with a foreign dest
    pkt = {16'h0005, 16'h0003, 16'h8000, 16'h1234, 16'h0001};
    for (int i = 0; i < 5; i++) send_flit(pkt[i], 1'b0);
    do_reset();
    pkt = {16'h00AB, 16'hBEEF, 16'hDEAD};
    send_packet(1'b0);

    // Same, but the tail's first word matches our address
    pkt = {16'h0005, 16'h0003, 16'h8000, 16'h1234, 16'h0001};
    for (int i = 0; i < 5; i++) send_flit(pkt[i], 1'b0);
    do_reset();
    pkt = {16'h0005, 16'hBEEF, 16'hDEAD};
    send_packet(1'b0);

    // Reset while holding an event discards it
    ev_block = 1'b1;
    build_good();
    send_packet(1'b0);
    do_reset();
    @(negedge clk);
    check_eq("hold_discarded", ev_valid, 1'b0);
    @(posedge clk);
    #1;
    ev_block = 1'b0;

    // Random mix of good and malformed packets
    for (int p = 0; p < 80; p++) begin
      build_good();
      kind = int'($urandom_range(0, 4));
      case (kind)
        1: begin
          w0 = 16'($urandom);
          if (w0[15:10] == 6'd0 && w0[9:0] == DutId) w0 = w0 ^ 16'h0400;
          pkt[0] = w0;
        end
        2: pkt[2] = 16'($urandom);
        3: begin
          w0 = 16'($urandom_range(1, PktLen - 1));
          while (pkt.size() > int'(w0)) void'(pkt.pop_back());
        end
        4: repeat ($urandom_range(1, 3)) pkt.push_back(16'($urandom));
        default: ;
      endcase
      send_packet(1'b1);
    end

    repeat (20) @(posedge clk);
    #1;
    check_eq("events_drained", 64'(exp_q.size()), 64'd0);
    check_eq("final_err_count", err_count, err_model);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_stm_event_rx.md
OSD_STM_EVENT_RX -- requirements
Module: osd_stm_event_rx

Interface
REQ-001 SHALL have parameter XLEN, default 32, value width in bits; SHALL be a multiple of 16.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port id, input, 10, own DII address.
REQ-005 SHALL have port debug_in, input, dii_flit (valid, last, data[15:0]), the incoming packet flits.
REQ-006 SHALL have port debug_in_ready, output, 1, flit accept strobe.
REQ-007 SHALL have port ev_valid, output, 1, decoded event available.
REQ-008 SHALL have port ev_ready, input, 1, event consumed.
REQ-009 SHALL have port ev_src, output, 16, source address of the event packet.
REQ-010 SHALL have port ev_timestamp, output, 32, event timestamp.
REQ-011 SHALL have port ev_id, output, 16, trace id.
REQ-012 SHALL have port ev_value, output, XLEN, trace value.
REQ-013 SHALL have port err_count, output, 16, count of malformed packets, saturating.

Function
REQ-014 SHALL transfer a flit only when debug_in.valid && debug_in_ready.
REQ-015 SHALL parse the packet in this flit order: dest, src, flags, ts[15:0], ts[31:16], id, value LSW first (XLEN/16 words); last SHALL be set on the final value word only.
REQ-016 SHALL run an FSM with states DEST, SRC, FLAGS, TS0, TS1, ID, VAL, DROP, HOLD; VAL SHALL use a word index counter 0..XLEN/16-1.
REQ-017 In DEST: dest[9:0]==id && dest[15:10]==0 -> SRC; otherwise -> DROP, with no error counted.
REQ-018 In FLAGS: flags[15:14]==2'b10 (EVENT) && flags[13:10]==0 -> TS0; otherwise -> DROP and err_count+1.
REQ-019 In VAL: the final word with last=1 -> HOLD; the final word with last=0 -> DROP and err_count+1.
REQ-020 A flit with last=1 in any state before the final VAL word SHALL return to DEST, increment err_count and produce no event.
REQ-021 A single-flit packet (dest flit with last=1) SHALL return to DEST; it SHALL count as an error only if the dest matches.
REQ-022 In DROP: flits SHALL be accepted and discarded; last=1 -> DEST.
REQ-023 debug_in_ready SHALL be 1 in every state except HOLD.
REQ-024 ev_valid SHALL be 1 exactly while in HOLD, starting the cycle after the last value flit is accepted (1-cycle latency).
REQ-025 ev_src, ev_timestamp, ev_id and ev_value SHALL remain stable while ev_valid=1.
REQ-026 In HOLD, ev_ready=1 -> DEST; the next packet's dest flit SHALL be accepted no earlier than the following cycle.
REQ-027 A valid/ready gap (debug_in.valid=0) SHALL hold the state and all partial fields.
REQ-028 err_count SHALL saturate at 16'hFFFF with no wrap.
REQ-029 Two error conditions in the same flit SHALL increment err_count once.

Reset
REQ-030 Reset SHALL force: state=DEST, ev_valid=0, err_count=0, word index=0, ev_* data=0; debug_in_ready SHALL be 1 after reset.
REQ-031 Reset mid-packet SHALL abandon the packet; its remaining flits SHALL be parsed as a new packet and handled by REQ-017/020.
REQ-032 Reset in HOLD SHALL discard the pending event without an ev_ready handshake.

Structure
REQ-033 The EVENT type code (2'b10), type_sub STM (4'h0) and an event struct typedef (src, timestamp, id, value) SHALL live in the shared opensocdebug package.
REQ-034 dii_flit SHALL come from dii_package.
REQ-035 The block SHALL be a single module with no sub-modules; the FSM, field registers and saturating counter are inline.

Verification
REQ-036 id=5, XLEN=32, flits 0005,0003,8000,1234,0001,00AB,BEEF,DEAD(last), ev_ready=1 -> one event: src=0003, ts=00011234, id=00AB, value=DEADBEEF, one cycle after the last flit; err_count=0.
REQ-037 Same packet with ev_ready held 0 for 10 cycles -> ev_valid and fields stable, debug_in_ready=0 for 10 cycles; a back-to-back second packet is accepted only after ev_ready.
REQ-038 dest=0007 with id=5, 8 flits -> all flits accepted, no event, err_count=0.
REQ-039 last=1 on the ID flit -> no event, err_count=1; the next good packet decodes correctly.
REQ-040 flags=4000, then last missing on the final value word with last on a 9th flit -> err_count=2, no events.
REQ-041 Reset asserted after the TS1 flit, then the remaining 3 flits -> no event, err_count=1 (dest mismatch possible -> 0, as checked per the dest data value).
